// File: rtl/microcode_sequencer.sv
// Opcode/micro-op enumerations shared with the microcode ROM, and the control-unit
// sequencer that walks the ROM through fetch and execute phases.
package OpcodePackage;
    typedef enum logic [7:0] {
        NXI  = 8'h00,
        ATB  = 8'h01,
        GPU  = 8'h02,
        HLT  = 8'h03,
        GDT7 = 8'h04,
        WMT  = 8'h05,
        WUT  = 8'h06,
        WFT  = 8'h07,
        WDD  = 8'h08,
        WCY  = 8'h09
    } Opcode_enum;
endpackage

package MicrocodePackage;
    typedef enum logic [7:0] {
        ENDMICRO   = 8'h00,
        NOP        = 8'h01,
        PC_to_MAR  = 8'h02,
        RAM_to_IR  = 8'h03,
        PC_inc     = 8'h04,
        A_to_B     = 8'h05,
        START_GPU  = 8'h06,
        WAIT_GPU   = 8'h07,
        WAIT_MT    = 8'h08,
        WAIT_UT    = 8'h09,
        WAIT_FT    = 8'h0A,
        WAIT_DD    = 8'h0B,
        WAIT_CYCLE = 8'h0C,
        HLT_CLK    = 8'h0D
    } Microcode_enum;
endpackage

module microcode_sequencer #(
    parameter int CYCLE_W   = 6,
    parameter int MAX_CYCLE = 63
) (
    input  logic                          clk,
    input  logic                          rst,
    input  OpcodePackage::Opcode_enum     ir_opcode,
    input  MicrocodePackage::Microcode_enum ucode,
    input  logic                          gpu_busy,
    input  logic                          mt_busy,
    input  logic                          ut_busy,
    input  logic                          ft_busy,
    input  logic                          dd_busy,
    input  logic                          resume,
    output OpcodePackage::Opcode_enum     operation,
    output logic [CYCLE_W-1:0]            cycle,
    output logic                          exec_en,
    output logic                          fetch_phase,
    output logic                          halted,
    output logic                          instr_done,
    output logic                          seq_err
);
    import OpcodePackage::*;
    import MicrocodePackage::*;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t              state_reg;
    Opcode_enum          operation_reg;
    logic [CYCLE_W-1:0]  cycle_reg;
    logic                fetch_phase_reg;
    logic                halted_reg;
    logic                instr_done_reg;
    logic                seq_err_reg;

    logic stalled;
    logic at_max;
    logic seq_end;

    // A wait op stalls only while its own busy line is high.
    always_comb begin
        stalled = 1'b0;
        case (ucode)
            WAIT_GPU: stalled = gpu_busy;
            WAIT_MT:  stalled = mt_busy;
            WAIT_UT:  stalled = ut_busy;
            WAIT_FT:  stalled = ft_busy;
            WAIT_DD:  stalled = dd_busy;
            default:  stalled = 1'b0;
        endcase
        at_max  = (cycle_reg == CYCLE_W'(MAX_CYCLE));
        seq_end = (ucode == ENDMICRO) || (at_max && !stalled);
        exec_en = !rst && (state_reg != HALT) && (ucode != ENDMICRO) && !stalled;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= FETCH;
            operation_reg   <= NXI;
            cycle_reg       <= '0;
            fetch_phase_reg <= 1'b1;
            halted_reg      <= 1'b0;
            instr_done_reg  <= 1'b0;
            seq_err_reg     <= 1'b0;
        end else begin
            instr_done_reg <= 1'b0;
            if (state_reg == HALT) begin
                if (resume) begin
                    state_reg       <= EXEC;
                    cycle_reg       <= cycle_reg + CYCLE_W'(1);
                    halted_reg      <= 1'b0;
                    fetch_phase_reg <= 1'b0;
                end
            end else if (!stalled) begin
                // Running off the end of the counter terminates the sequence as if ENDMICRO.
                if (at_max && (ucode != ENDMICRO))
                    seq_err_reg <= 1'b1;
                if (seq_end) begin
                    cycle_reg <= '0;
                    if (state_reg == FETCH) begin
                        operation_reg   <= ir_opcode;
                        state_reg       <= EXEC;
                        fetch_phase_reg <= 1'b0;
                    end else begin
                        operation_reg   <= NXI;
                        state_reg       <= FETCH;
                        fetch_phase_reg <= 1'b1;
                        instr_done_reg  <= 1'b1;
                    end
                end else if (ucode == HLT_CLK) begin
                    state_reg  <= HALT;
                    halted_reg <= 1'b1;
                end else begin
                    cycle_reg <= cycle_reg + CYCLE_W'(1);
                end
            end
        end
    end

    assign operation   = operation_reg;
    assign cycle       = cycle_reg;
    assign fetch_phase = fetch_phase_reg;
    assign halted      = halted_reg;
    assign instr_done  = instr_done_reg;
    assign seq_err     = seq_err_reg;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: a behavioural ROM, directed scenarios and a
// randomized run compared clock by clock against an abstract sequencer model.
module tb_microcode_sequencer;
    import OpcodePackage::*;
    import MicrocodePackage::*;

    localparam int MAXC = 63;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    Opcode_enum    ir_opcode = NXI;
    Microcode_enum ucode;
    logic gpu_busy = 0, mt_busy = 0, ut_busy = 0, ft_busy = 0, dd_busy = 0, resume = 0;
    Opcode_enum    operation;
    logic [5:0]    cycle;
    logic          exec_en, fetch_phase, halted, instr_done, seq_err;
    bit            stub = 1'b0;

    int errors = 0;
    int checks = 0;

    // model state: phase 0=fetch 1=execute 2=halted
    int         m_phase;
    Opcode_enum m_op;
    int         m_cyc;
    bit         m_done, m_err;

    microcode_sequencer #(.CYCLE_W(6), .MAX_CYCLE(MAXC)) dut (
        .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .ucode(ucode),
        .gpu_busy(gpu_busy), .mt_busy(mt_busy), .ut_busy(ut_busy),
        .ft_busy(ft_busy), .dd_busy(dd_busy), .resume(resume),
        .operation(operation), .cycle(cycle), .exec_en(exec_en),
        .fetch_phase(fetch_phase), .halted(halted), .instr_done(instr_done),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    function automatic Microcode_enum rom(Opcode_enum op, int cyc, bit stb);
        if (stb) return A_to_B;
        case (op)
            NXI: case (cyc)
                    0: return PC_to_MAR;
                    1: return RAM_to_IR;
                    2: return PC_inc;
                    3: return NOP;
                    default: return ENDMICRO;
                 endcase
            ATB:  return (cyc == 0) ? A_to_B : ENDMICRO;
            GPU:  return (cyc == 0) ? WAIT_GPU : (cyc == 1) ? START_GPU : ENDMICRO;
            HLT:  return (cyc == 0) ? HLT_CLK : ENDMICRO;
            GDT7: return (cyc >= 20) ? ENDMICRO : ((cyc % 3) == 2) ? WAIT_CYCLE : A_to_B;
            WMT:  return (cyc == 0) ? WAIT_MT : (cyc == 1) ? NOP : ENDMICRO;
            WUT:  return (cyc == 0) ? WAIT_UT : (cyc == 1) ? NOP : ENDMICRO;
            WFT:  return (cyc == 0) ? WAIT_FT : (cyc == 1) ? NOP : ENDMICRO;
            WDD:  return (cyc == 0) ? WAIT_DD : (cyc == 1) ? NOP : ENDMICRO;
            WCY:  return (cyc < 2) ? WAIT_CYCLE : ENDMICRO;
            default: return ENDMICRO;
        endcase
    endfunction

    always_comb ucode = rom(operation, int'(cycle), stub);

    function automatic bit waiting(Microcode_enum u);
        case (u)
            WAIT_GPU: return gpu_busy;
            WAIT_MT:  return mt_busy;
            WAIT_UT:  return ut_busy;
            WAIT_FT:  return ft_busy;
            WAIT_DD:  return dd_busy;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic bit m_exec_en();
        Microcode_enum u = rom(m_op, m_cyc, stub);
        return (m_phase != 2) && (u != ENDMICRO) && !waiting(u);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_op = NXI; m_cyc = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        Microcode_enum u = rom(m_op, m_cyc, stub);
        bit hold = waiting(u);
        m_done = 0;
        if (m_phase == 2) begin
            if (resume) begin
                m_phase = 1;
                m_cyc = (m_cyc + 1) % (MAXC + 1);
            end
        end else if (!hold) begin
            if (m_cyc == MAXC && u != ENDMICRO) m_err = 1;
            if (u == ENDMICRO || m_cyc == MAXC) begin
                m_cyc = 0;
                if (m_phase == 0) begin
                    m_op = ir_opcode; m_phase = 1;
                end else begin
                    m_op = NXI; m_phase = 0; m_done = 1;
                end
            end else if (u == HLT_CLK) begin
                m_phase = 2;
            end else begin
                m_cyc = m_cyc + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({operation, cycle, exec_en, fetch_phase, halted, instr_done, seq_err} !==
            {NXI, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_state got=%h exp=%h",
                {operation, cycle, exec_en, fetch_phase, halted, instr_done, seq_err},
                {NXI, 6'd0, 5'b01000});
        else $display("reset: outputs at reset values");
        if ({operation, cycle, exec_en, fetch_phase} !== {NXI, 6'd0, 1'b0, 1'b1}) errors++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_atb();
        int  exp_cyc[7] = '{0, 1, 2, 3, 4, 0, 1};
        bit  exp_en[7]  = '{1, 1, 1, 1, 0, 1, 0};
        bit  exp_fp[7]  = '{1, 1, 1, 1, 1, 0, 0};
        ir_opcode = ATB;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({cycle, exec_en, fetch_phase} !== {6'(exp_cyc[i]), exp_en[i], exp_fp[i]}) begin
                errors++;
                $display("FAIL atb_step%0d got cyc=%0d en=%b fp=%b exp cyc=%0d en=%b fp=%b",
                    i, cycle, exec_en, fetch_phase, exp_cyc[i], exp_en[i], exp_fp[i]);
            end
            if (i >= 5) begin
                checks++;
                if (operation !== ATB) begin
                    errors++;
                    $display("FAIL atb_operation got=%0d exp=%0d", operation, ATB);
                end
            end
            tick();
        end
        checks++;
        if ({operation, cycle, fetch_phase, instr_done} !== {NXI, 6'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL atb_done got op=%0d cyc=%0d fp=%b done=%b exp op=0 cyc=0 fp=1 done=1",
                operation, cycle, fetch_phase, instr_done);
        end
        $display("atb: instruction complete in 7 clocks");
    endtask

    task automatic run_fetch(string tag);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({fetch_phase, instr_done, cycle} !== {1'b1, (i == 0), 6'(i)}) begin
                errors++;
                $display("FAIL %s_fetch%0d got fp=%b done=%b cyc=%0d exp fp=1 done=%0d cyc=%0d",
                    tag, i, fetch_phase, instr_done, cycle, (i == 0), i);
            end
            tick();
        end
    endtask

    task automatic test_gpu_wait();
        ir_opcode = GPU;
        gpu_busy = 1'b1;
        run_fetch("gpu");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({operation, cycle, exec_en, fetch_phase} !== {GPU, 6'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL gpu_stall%0d got op=%0d cyc=%0d en=%b fp=%b exp op=%0d cyc=0 en=0 fp=0",
                    i, operation, cycle, exec_en, fetch_phase, GPU);
            end
            tick();
        end
        gpu_busy = 1'b0;
        #1;
        checks++;
        if ({cycle, exec_en} !== {6'd0, 1'b1}) begin
            errors++;
            $display("FAIL gpu_release got cyc=%0d en=%b exp cyc=0 en=1", cycle, exec_en);
        end
        tick();
        checks++;
        if ({cycle, exec_en} !== {6'd1, 1'b1}) begin
            errors++;
            $display("FAIL gpu_start got cyc=%0d en=%b exp cyc=1 en=1", cycle, exec_en);
        end
        tick();
        checks++;
        if ({cycle, exec_en} !== {6'd2, 1'b0}) begin
            errors++;
            $display("FAIL gpu_end got cyc=%0d en=%b exp cyc=2 en=0", cycle, exec_en);
        end
        tick();
        checks++;
        if ({fetch_phase, instr_done, operation, cycle} !== {1'b1, 1'b1, NXI, 6'd0}) begin
            errors++;
            $display("FAIL gpu_done got fp=%b done=%b op=%0d cyc=%0d exp fp=1 done=1 op=0 cyc=0",
                fetch_phase, instr_done, operation, cycle);
        end
        $display("gpu: wait released after 5 stall clocks");
    endtask

    task automatic test_halt();
        ir_opcode = HLT;
        run_fetch("hlt");
        checks++;
        if ({exec_en, halted, cycle} !== {1'b1, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL hlt_clk got en=%b halted=%b cyc=%0d exp en=1 halted=0 cyc=0",
                exec_en, halted, cycle);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({halted, exec_en, cycle, fetch_phase} !== {1'b1, 1'b0, 6'd0, 1'b0}) begin
                errors++;
                $display("FAIL hlt_hold%0d got halted=%b en=%b cyc=%0d fp=%b exp halted=1 en=0 cyc=0 fp=0",
                    i, halted, exec_en, cycle, fetch_phase);
            end
            tick();
        end
        resume = 1'b1;
        #1;
        checks++;
        if ({halted, exec_en} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hlt_resume_comb got halted=%b en=%b exp halted=1 en=0", halted, exec_en);
        end
        tick();
        resume = 1'b0;
        checks++;
        if ({halted, cycle, exec_en} !== {1'b0, 6'd1, 1'b0}) begin
            errors++;
            $display("FAIL hlt_resumed got halted=%b cyc=%0d en=%b exp halted=0 cyc=1 en=0",
                halted, cycle, exec_en);
        end
        tick();
        checks++;
        if ({instr_done, fetch_phase} !== 2'b11) begin
            errors++;
            $display("FAIL hlt_done got done=%b fp=%b exp done=1 fp=1", instr_done, fetch_phase);
        end
        $display("halt: held 10 clocks then resumed");
    endtask

    task automatic test_stall_resume();
        ir_opcode = WMT;
        mt_busy = 1'b1;
        resume = 1'b1;
        run_fetch("wmt");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({halted, cycle, exec_en, fetch_phase} !== {1'b0, 6'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL wmt_stall%0d got halted=%b cyc=%0d en=%b fp=%b exp halted=0 cyc=0 en=0 fp=0",
                    i, halted, cycle, exec_en, fetch_phase);
            end
            tick();
        end
        mt_busy = 1'b0;
        resume = 1'b0;
        #1;
        checks++;
        if (exec_en !== 1'b1) begin
            errors++;
            $display("FAIL wmt_release got en=%b exp en=1", exec_en);
        end
        tick();
        tick();
        tick();
        checks++;
        if ({fetch_phase, instr_done} !== 2'b11) begin
            errors++;
            $display("FAIL wmt_done got fp=%b done=%b exp fp=1 done=1", fetch_phase, instr_done);
        end
        $display("stall_resume: resume ignored during wait stall");
    endtask

    task automatic test_overflow();
        stub = 1'b1;
        ir_opcode = ATB;
        for (int i = 0; i <= MAXC; i++) begin
            checks++;
            if ({cycle, exec_en, fetch_phase, seq_err} !== {6'(i), 1'b1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL ovf_count%0d got cyc=%0d en=%b fp=%b err=%b exp cyc=%0d en=1 fp=1 err=0",
                    i, cycle, exec_en, fetch_phase, seq_err, i);
            end
            tick();
        end
        checks++;
        if ({cycle, fetch_phase, operation, seq_err} !== {6'd0, 1'b0, ATB, 1'b1}) begin
            errors++;
            $display("FAIL ovf_wrap got cyc=%0d fp=%b op=%0d err=%b exp cyc=0 fp=0 op=%0d err=1",
                cycle, fetch_phase, operation, seq_err, ATB);
        end
        stub = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (seq_err !== 1'b1) begin
                errors++;
                $display("FAIL ovf_sticky%0d got err=%b exp err=1", i, seq_err);
            end
        end
        $display("overflow: wrapped at %0d, error flag sticky", MAXC);
    endtask

    task automatic test_async_reset();
        int n = 0;
        ir_opcode = GDT7;
        run_fetch("gdt7");
        while (cycle != 6'd10 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if ({operation, cycle} !== {GDT7, 6'd10}) begin
            errors++;
            $display("FAIL gdt7_reach got op=%0d cyc=%0d exp op=%0d cyc=10", operation, cycle, GDT7);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({operation, cycle, exec_en, halted, seq_err, fetch_phase, instr_done} !==
            {NXI, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got op=%0d cyc=%0d en=%b halted=%b err=%b fp=%b exp op=0 cyc=0 en=0 halted=0 err=0 fp=1",
                operation, cycle, exec_en, halted, seq_err, fetch_phase);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("async_reset: outputs cleared without a clock edge");
    endtask

    task automatic test_random();
        Opcode_enum ops[10] = '{NXI, ATB, GPU, HLT, GDT7, WMT, WUT, WFT, WDD, WCY};
        int done_cnt = 0;
        for (int t = 0; t < 800; t++) begin
            ir_opcode = ops[$urandom_range(0, 9)];
            gpu_busy  = ($urandom_range(0, 1) == 0);
            mt_busy   = ($urandom_range(0, 1) == 0);
            ut_busy   = ($urandom_range(0, 2) == 0);
            ft_busy   = ($urandom_range(0, 1) == 0);
            dd_busy   = ($urandom_range(0, 2) == 0);
            resume    = ($urandom_range(0, 3) == 0);
            #1;
            checks += 7;
            if (operation !== m_op) begin
                errors++; $display("FAIL rnd_operation t=%0d got=%0d exp=%0d", t, operation, m_op);
            end
            if (int'(cycle) != m_cyc) begin
                errors++; $display("FAIL rnd_cycle t=%0d got=%0d exp=%0d", t, cycle, m_cyc);
            end
            if (exec_en !== m_exec_en()) begin
                errors++; $display("FAIL rnd_exec_en t=%0d got=%b exp=%b", t, exec_en, m_exec_en());
            end
            if (fetch_phase !== (m_phase == 0)) begin
                errors++; $display("FAIL rnd_fetch_phase t=%0d got=%b exp=%b", t, fetch_phase, m_phase == 0);
            end
            if (halted !== (m_phase == 2)) begin
                errors++; $display("FAIL rnd_halted t=%0d got=%b exp=%b", t, halted, m_phase == 2);
            end
            if (instr_done !== m_done) begin
                errors++; $display("FAIL rnd_instr_done t=%0d got=%b exp=%b", t, instr_done, m_done);
            end
            if (seq_err !== m_err) begin
                errors++; $display("FAIL rnd_seq_err t=%0d got=%b exp=%b", t, seq_err, m_err);
            end
            if (instr_done) begin
                done_cnt++;
                $display("random: instruction %0d complete at step %0d", done_cnt, t);
            end
            tick();
        end
        checks++;
        if (done_cnt < 5) begin
            errors++;
            $display("FAIL rnd_progress got=%0d instructions exp>=5", done_cnt);
        end
        resume = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_atb();
        test_gpu_wait();
        test_halt();
        test_stall_resume();
        test_overflow();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Control-unit sequencer directly upstream of the Opcodes microcode ROM.
- Drives the ROM's `operation` and `cycle` inputs and consumes its `ucode` output.
- Alternates fetch (NXI) and execute phases, stalls on wait micro-ops, and handles halt/resume.
- Issues `exec_en` to qualify `ucode` for the datapath.

Parameters:
- CYCLE_W, 6, width of micro-cycle counter; must match the ROM's cycle input.
- MAX_CYCLE, 63, last legal micro-cycle before forced termination.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ir_opcode  in  OpcodePackage::Opcode_enum  current IR contents (valid after RAM_to_IR).
- ucode  in  MicrocodePackage::Microcode_enum  ROM output for (operation, cycle).
- gpu_busy  in  1  GPU busy; stalls WAIT_GPU.
- mt_busy  in  1  ms timer running; stalls WAIT_MT.
- ut_busy  in  1  us timer running; stalls WAIT_UT.
- ft_busy  in  1  frame period not elapsed; stalls WAIT_FT.
- dd_busy  in  1  BCD/double-dabble busy; stalls WAIT_DD.
- resume  in  1  leaves HALT (level, sampled per clock).
- operation  out  OpcodePackage::Opcode_enum  opcode presented to ROM.
- cycle  out  CYCLE_W  micro-cycle presented to ROM.
- exec_en  out  1  datapath may act on ucode this clock.
- fetch_phase  out  1  high while operation is the fetch sequence.
- halted  out  1  sequencer in HALT.
- instr_done  out  1  one-clock pulse when an instruction's execute phase ends.
- seq_err  out  1  sticky: MAX_CYCLE reached without ENDMICRO.

Behaviour:
- States: FETCH, EXEC, HALT.
- Reset (async, any time, including mid-instruction or in HALT): FETCH, operation=NXI, cycle=0, halted=0, instr_done=0, seq_err=0, fetch_phase=1.
- exec_en is combinational: 0 while rst is high.
- Registered outputs change only on the clk rising edge.
- FETCH/EXEC per clock, priority order:
  1. ucode==ENDMICRO: exec_en=0; cycle<=0.
     - From FETCH: operation<=ir_opcode, go to EXEC.
     - From EXEC: operation<=NXI, go to FETCH, instr_done=1 next clock.
  2. Wait op (WAIT_GPU/MT/UT/FT/DD) with its busy input high: exec_en=0; cycle held.
  3. Wait op with busy low: exec_en=1; cycle<=cycle+1.
  4. HLT_CLK: exec_en=1 for that clock; go to HALT; cycle held.
  5. Any other op, including WAIT_CYCLE (fixed one-clock delay): exec_en=1; cycle<=cycle+1.
- Overflow: cycle==MAX_CYCLE with ucode != ENDMICRO:
  - exec_en=1 (op executes).
  - Next state as for ENDMICRO from the current phase (cycle<=0).
  - seq_err<=1, sticky until reset.
  - Applies to wait ops only once their busy is low; stalls are never aborted.
- HALT: exec_en=0, halted=1, cycle and operation held.
  - resume high: go to EXEC with cycle<=cycle+1, halted<=0 next clock.
  - resume is ignored outside HALT.
- ir_opcode is sampled only on the FETCH→EXEC transition.
- ir_opcode==NXI is legal and re-runs fetch (acts as NOP).
- fetch_phase = (state==FETCH).
- instr_done is high exactly one clock, the clock after the EXEC→FETCH edge.
- Latency: zero-wait instruction of N micro-ops costs fetch 5 clocks (4 ops + ENDMICRO) + N+1 execute clocks.

Test Plan:
- Reset, ROM connected, ir_opcode=ATB:
  - cycle 0..4 in FETCH, then operation=ATB, cycle 0.
  - exec_en=1 on A_to_B, 0 on ENDMICRO.
  - instr_done pulses once; second fetch starts with operation=NXI, cycle=0; total 7 clocks.
- ir_opcode=GPU, gpu_busy held 5 clocks then low:
  - cycle stays 0 with exec_en=0 for 5 clocks.
  - WAIT_GPU clock with busy low: exec_en=1, cycle advances.
  - START_GPU executes at cycle 1; ENDMICRO at cycle 2.
- ir_opcode=HLT:
  - HLT_CLK exec_en=1, then halted=1 for 10 clocks with resume=0 (cycle frozen at 0).
  - resume pulse → halted=0, cycle=1 (ENDMICRO), then instr_done, then FETCH.
- Stub ROM never returning ENDMICRO:
  - cycle counts 0..63, then wraps to 0.
  - Phase toggles; seq_err=1 and stays 1 through further normal instructions until rst.
- ir_opcode=GDT7, rst asserted asynchronously mid-clock at cycle 10:
  - Outputs go immediately to operation=NXI, cycle=0, exec_en=0, halted=0, seq_err=0, without waiting for clk.
- Simultaneous: WAIT_MT with mt_busy high and resume high → stall holds, resume ignored, halted stays 0.
